flow_key_hash_feeder: RTL and testbench

- Upstream stage of simple_hash.
- Accepts a full flow key (5-tuple, 104 bits) over a valid/ready handshake.
- Slices the key into HASH_WORD_WIDTH words and presents one word per cycle to the combinational simple_hash.
- Folds the returned HASH_RESULT_WIDTH results into a single flow hash, which it delivers downstream to the flow-table lookup over a valid/ready handshake.

---
 rtl/flow_key_hash_feeder.sv | 150 +++++++++++++++
 tb/tb_flow_key_hash_feeder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_key_hash_feeder.sv
// -----------------------------------------------------------------------------
// flow_key_hash_feeder
//
// Upstream stage of simple_hash. Accepts a flow key over a valid/ready
// handshake, presents it to the combinational simple_hash one
// WORD_WIDTH-bit slice per cycle (word 0 = LSBs, last word zero-padded),
// and folds the returned results into a single RESULT_WIDTH-bit flow hash:
//   acc <= rotl1(acc) ^ hash_result
// The folded hash is then offered downstream over a valid/ready handshake.
//
// Ports:
//   clk             rising-edge clock
//   reset_n         synchronous active-low reset
//   key_in          flow key (KEY_WIDTH)
//   key_valid       key_in is valid
//   key_ready       block accepts a key this cycle (high in IDLE)
//   hash_word       word driven to simple_hash data_in (0 outside FEED)
//   hash_word_valid hash_word is meaningful (high only in FEED)
//   hash_result     simple_hash data_out, combinational from hash_word
//   out_hash        folded flow hash, held until overwritten by the next key
//   out_valid       out_hash is valid
//   out_ready       downstream accepts out_hash
// -----------------------------------------------------------------------------
`ifndef HASH_WORD_WIDTH
`define HASH_WORD_WIDTH 32
`endif
`ifndef HASH_RESULT_WIDTH
`define HASH_RESULT_WIDTH 16
`endif

module flow_key_hash_feeder #(
  parameter int KEY_WIDTH    = 104,
  parameter int WORD_WIDTH   = `HASH_WORD_WIDTH,
  parameter int RESULT_WIDTH = `HASH_RESULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [KEY_WIDTH-1:0]    key_in,
  input  logic                    key_valid,
  output logic                    key_ready,
  output logic [WORD_WIDTH-1:0]   hash_word,
  output logic                    hash_word_valid,
  input  logic [RESULT_WIDTH-1:0] hash_result,
  output logic [RESULT_WIDTH-1:0] out_hash,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int NWORDS   = (KEY_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int PADDED_W = NWORDS * WORD_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PADDED_W-1:0]     key_q;
  logic [PADDED_W-1:0]     key_pad;
  logic [IDX_W-1:0]        index_q;
  logic [RESULT_WIDTH-1:0] acc_q;
  logic [RESULT_WIDTH-1:0] fold;
  logic                    last_word;
  logic [WORD_WIDTH-1:0]   words [NWORDS];

  // Zero-extend the key to a whole number of words so the final slice
  // carries zeros above bit KEY_WIDTH-1 (no-op when widths divide evenly).
  always_comb begin
    key_pad                = '0;
    key_pad[KEY_WIDTH-1:0] = key_in;
  end

  for (genvar i = 0; i < NWORDS; i++) begin : g_slice
    assign words[i] = key_q[i*WORD_WIDTH +: WORD_WIDTH];
  end

  assign last_word = (index_q == IDX_W'(NWORDS - 1));
  // Fold step: rotate left by one within RESULT_WIDTH, then XOR in the result.
  assign fold = {acc_q[RESULT_WIDTH-2:0], acc_q[RESULT_WIDTH-1]} ^ hash_result;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and Moore outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would infer a latch.
    state_d         = state_q;
    key_ready       = 1'b0;
    hash_word_valid = 1'b0;
    hash_word       = '0;
    unique case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_d = FEED;
      end
      FEED: begin
        hash_word_valid = 1'b1;
        hash_word       = words[index_q];
        if (last_word) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: key register, word index, accumulator and output register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_q     <= '0;
      index_q   <= '0;
      acc_q     <= '0;
      out_hash  <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (key_valid) begin
            key_q   <= key_pad;
            index_q <= '0;
            acc_q   <= '0;
          end
        end
        FEED: begin
          acc_q   <= fold;
          index_q <= index_q + IDX_W'(1);
          if (last_word) begin
            out_hash  <= fold;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // out_hash is deliberately left untouched after the handshake.
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_flow_key_hash_feeder.sv
// -----------------------------------------------------------------------------
// tb_flow_key_hash_feeder
//
// Self-checking bench for flow_key_hash_feeder. A hash stub stands in for
// simple_hash (identity on the low 16 bits, or a mixing function for the
// random run). A transaction-level model (queues of expected words and
// pending hashes) is compared against the DUT outputs on every falling edge.
// -----------------------------------------------------------------------------
module tb_flow_key_hash_feeder;

  localparam int KW = 104;
  localparam int WW = 32;
  localparam int RW = 16;
  localparam int NW = 4;

  localparam logic [KW-1:0] K1 = {8'h04, 32'h3, 32'h2, 32'h1};
  localparam logic [KW-1:0] K2 = {KW{1'b1}};

  logic          clk = 1'b0;
  logic          reset_n;
  logic [KW-1:0] key_in;
  logic          key_valid;
  logic          key_ready;
  logic [WW-1:0] hash_word;
  logic          hash_word_valid;
  logic [RW-1:0] hash_result;
  logic [RW-1:0] out_hash;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  flow_key_hash_feeder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .key_in          (key_in),
    .key_valid       (key_valid),
    .key_ready       (key_ready),
    .hash_word       (hash_word),
    .hash_word_valid (hash_word_valid),
    .hash_result     (hash_result),
    .out_hash        (out_hash),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  // ---------------------------------------------------------------------------
  // Hash stub and reference fold
  // ---------------------------------------------------------------------------
  int mode = 0;  // 0: identity stub, 1: mixing stub

  function automatic logic [RW-1:0] stub(input logic [WW-1:0] w, input int m);
    logic [RW-1:0] p;
    if (m == 0) return w[15:0];
    p = w[15:0] * 16'h9E37;
    return p ^ w[31:16] ^ {w[7:0], w[15:8]};
  endfunction

  assign hash_result = stub(hash_word, mode);

  function automatic logic [WW-1:0] word_of(input logic [KW-1:0] k, input int i);
    logic [NW*WW-1:0] p;
    p = (NW*WW)'(k);
    return p[i*WW +: WW];
  endfunction

  function automatic logic [RW-1:0] model_hash(input logic [KW-1:0] k, input int m);
    logic [RW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NW; i++)
      acc = {acc[RW-2:0], acc[RW-1]} ^ stub(word_of(k, i), m);
    return acc;
  endfunction

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Transaction model + per-cycle compare
  // ---------------------------------------------------------------------------
  logic [WW-1:0] exp_words[$];
  logic [RW-1:0] exp_pend[$];
  logic [RW-1:0] exp_last = '0;
  bit            mon_en = 1'b0;
  bit            busy;

  always @(negedge clk) begin
    if (mon_en) begin
      busy = (exp_words.size() != 0) || (exp_pend.size() != 0);
      check("key_ready", key_ready, !busy);
      check("hash_word_valid", hash_word_valid, exp_words.size() != 0);
      check("hash_word", hash_word, (exp_words.size() != 0) ? exp_words[0] : '0);
      check("out_valid", out_valid, (exp_words.size() == 0) && (exp_pend.size() != 0));
      check("out_hash", out_hash, exp_last);

      // Advance the model to what the coming rising edge must produce.
      if (!reset_n) begin
        exp_words.delete();
        exp_pend.delete();
        exp_last = '0;
      end else if (exp_words.size() != 0) begin
        if (exp_words.size() == 1) exp_last = exp_pend[0];
        void'(exp_words.pop_front());
      end else if (exp_pend.size() != 0) begin
        if (out_ready) void'(exp_pend.pop_front());
      end else if (key_valid) begin
        for (int i = 0; i < NW; i++) exp_words.push_back(word_of(key_in, i));
        exp_pend.push_back(model_hash(key_in, mode));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string name, output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (!out_valid) check({name, "_timeout"}, 1'b0, 1'b1);
  endtask

  int            lat;
  int            nres;
  int            accepted;
  int            cyc;
  logic [RW-1:0] res [$];

  initial begin
    reset_n   = 1'b0;
    key_in    = '0;
    key_valid = 1'b0;
    out_ready = 1'b0;

    // Pin the reference model with hand-computed results.
    check("model_s1", model_hash(K1, 0), 16'h0002);
    check("model_s2", model_hash(K2, 0), 16'hFF00);
    check("model_w3", word_of(K2, 3), 32'h0000_00FF);

    step();
    mon_en = 1'b1;
    step();
    check("rst_key_ready", key_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_hash", out_hash, 16'h0000);
    check("rst_hash_word", hash_word, 32'h0);
    reset_n = 1'b1;
    step();

    // Scenario 1: word sequence and latency; out_ready held low afterwards.
    key_in = K1; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    wait_out_valid("s1", lat);
    check("s1_latency", lat, NW);
    check("s1_hash", out_hash, 16'h0002);

    // Scenario 3: 10 cycles of backpressure with an ignored key.
    for (int i = 0; i < 10; i++) begin
      key_in    = K2;
      key_valid = (i == 4);
      step();
    end
    key_valid = 1'b0;
    check("s3_hash_held", out_hash, 16'h0002);
    check("s3_valid_held", out_valid, 1'b1);
    out_ready = 1'b1;
    step();
    check("s3_idle_ready", key_ready, 1'b1);
    check("s3_valid_drop", out_valid, 1'b0);
    check("s3_hash_retained", out_hash, 16'h0002);

    // Scenario 2: all-ones key.
    key_in = K2; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    wait_out_valid("s2", lat);
    check("s2_hash", out_hash, 16'hFF00);
    step();
    step();

    // Scenario 4: reset after word 1 aborts the key.
    key_in = K2; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("s4_key_ready", key_ready, 1'b1);
    check("s4_out_valid", out_valid, 1'b0);
    check("s4_out_hash", out_hash, 16'h0000);
    check("s4_hw_valid", hash_word_valid, 1'b0);
    repeat (8) step();
    key_in = K1; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    wait_out_valid("s4", lat);
    check("s4_hash", out_hash, 16'h0002);
    step();
    step();

    // Scenario 5: back-to-back, alternating keys, out_ready tied high.
    key_in = K1; key_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 36; i++) begin
      bit acc_now;
      acc_now = key_ready;
      if (out_valid) res.push_back(out_hash);
      step();
      if (acc_now) key_in = (key_in == K1) ? K2 : K1;
    end
    key_valid = 1'b0;
    nres = res.size();
    check("s5_count", nres, 6);
    for (int i = 0; i < nres; i++)
      check("s5_seq", res[i], (i % 2 == 0) ? 16'h0002 : 16'hFF00);
    repeat (8) step();

    // Scenario 6: random keys with the mixing stub and random handshakes.
    mode     = 1;
    accepted = 0;
    cyc      = 0;
    while (accepted < 100 && cyc < 3000) begin
      key_in    = KW'({$urandom(), $urandom(), $urandom(), $urandom()});
      key_valid = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1);
      if (key_valid && key_ready) accepted++;
      step();
      cyc++;
    end
    check("s6_accepted", accepted, 100);
    key_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
